// File: rtl/sys_pkg.sv
// Shared definitions for the writeback stage: exception cause codes,
// system-register indices and the trap/IRET sequencer states.
package sys_pkg;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_ITLB = 2'd1;
    localparam logic [1:0] CAUSE_DTLB = 2'd2;
    localparam logic [1:0] CAUSE_PRIV = 2'd3;

    localparam logic [2:0] RM_EPC     = 3'd0;
    localparam logic [2:0] RM_EADDR   = 3'd1;
    localparam logic [2:0] RM_CAUSE   = 3'd2;
    localparam logic [2:0] RM_SCRATCH = 3'd3;
    localparam logic [2:0] RM_MODE    = 3'd4;
    localparam logic [2:0] RM_LAST    = RM_MODE;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // A D-TLB miss also raises the combined miss bit, so it must be tested first.
    function automatic logic [1:0] causeOf(input logic tlbMissD, input logic tlbMissM);
        logic [1:0] cause;
        if (tlbMissD)
            cause = CAUSE_DTLB;
        else if (tlbMissM)
            cause = CAUSE_ITLB;
        else
            cause = CAUSE_PRIV;
        return cause;
    endfunction

endpackage

// File: rtl/sys_regfile.sv
// Exception system registers rm0..rm4: one software write port, one
// bulk-capture port used on traps, and a combinational read port.
module sys_regfile
    import sys_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic        cap_en_i,
    input  logic [31:0] cap_pc_i,
    input  logic [31:0] cap_addr_i,
    input  logic [1:0]  cap_cause_i,
    input  logic        cap_mode_i,
    input  logic [2:0]  rd_idx_i,
    output logic [31:0] rd_data_o,
    output logic [31:0] epc_o,
    output logic        saved_mode_o
);

    logic [31:0] rm_q [5];

    // Capture and software write never coincide upstream; capture wins regardless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 5; i++)
                rm_q[i] <= '0;
        end else if (cap_en_i) begin
            rm_q[RM_EPC]   <= cap_pc_i;
            rm_q[RM_EADDR] <= cap_addr_i;
            rm_q[RM_CAUSE] <= {30'b0, cap_cause_i};
            rm_q[RM_MODE]  <= {31'b0, cap_mode_i};
        end else if (wr_en_i && (wr_idx_i <= RM_LAST)) begin
            rm_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_idx_i <= RM_LAST)
            rd_data_o = rm_q[rd_idx_i];
    end

    assign epc_o        = rm_q[RM_EPC];
    assign saved_mode_o = rm_q[RM_MODE][0];

endmodule

// File: rtl/wb_stage.sv
// Final pipeline stage: GPR writeback selection plus the privilege mode,
// exception capture and the trap/IRET flush sequencer.
module wb_stage
    import sys_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_2000,
    parameter int unsigned FLUSH_CYCLES    = 2,
    parameter bit          BOOT_SUPERVISOR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        injected_nop_init,
    input  logic        WB_EN_INIT,
    input  logic        MEM_TO_REG_INIT,
    input  logic [31:0] read_data_mem,
    input  logic [31:0] alu_result,
    input  logic [4:0]  regD_init,
    input  logic        WB_SYS_EN_INIT,
    input  logic        is_IRET_INIT,
    input  logic        TLB_MISS_M_INIT,
    input  logic        TLB_MISS_D_INIT,
    input  logic [31:0] PC_INIT,
    input  logic [31:0] ADDRESS_INIT,
    input  logic [2:0]  sys_rd_idx,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic [31:0] sys_rd_data,
    output logic        supervisor_mode,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] pc_redirect_target,
    output logic        exc_pending
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sup_q, sup_d;
    logic        redir_q, redir_d;
    logic [31:0] target_q, target_d;

    logic        live;
    logic        priv;
    logic        fault;
    logic        iretTake;
    logic        sysWrite;
    logic [31:0] epc;
    logic        savedMode;

    // IRET from user mode is treated exactly like a privileged sys write.
    assign live     = valid_in & ~injected_nop_init & (state_q == ST_RUN);
    assign priv     = (WB_SYS_EN_INIT | is_IRET_INIT) & ~sup_q;
    assign fault    = live & (TLB_MISS_M_INIT | priv);
    assign iretTake = live & is_IRET_INIT & ~fault;
    assign sysWrite = live & WB_SYS_EN_INIT & sup_q & ~fault & ~is_IRET_INIT;

    assign reg_we    = live & WB_EN_INIT & ~fault;
    assign reg_waddr = regD_init;
    assign reg_wdata = MEM_TO_REG_INIT ? read_data_mem : alu_result;

    sys_regfile u_sys_regfile (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (sysWrite),
        .wr_idx_i     (regD_init[2:0]),
        .wr_data_i    (alu_result),
        .cap_en_i     (fault),
        .cap_pc_i     (PC_INIT),
        .cap_addr_i   (ADDRESS_INIT),
        .cap_cause_i  (causeOf(TLB_MISS_D_INIT, TLB_MISS_M_INIT)),
        .cap_mode_i   (sup_q),
        .rd_idx_i     (sys_rd_idx),
        .rd_data_o    (sys_rd_data),
        .epc_o        (epc),
        .saved_mode_o (savedMode)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sup_d    = sup_q;
        redir_d  = 1'b0;
        target_d = target_q;
        if (state_q == ST_RUN) begin
            if (fault) begin
                sup_d    = 1'b1;
                redir_d  = 1'b1;
                target_d = EXC_VECTOR;
                cnt_d    = FLUSH_LOAD;
                state_d  = ST_FLUSH;
            end else if (iretTake) begin
                sup_d    = savedMode;
                redir_d  = 1'b1;
                target_d = epc;
                cnt_d    = FLUSH_LOAD;
                state_d  = ST_FLUSH;
            end
        end else begin
            if (cnt_q <= 3'd1) begin
                cnt_d   = 3'd0;
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            cnt_q    <= 3'd0;
            sup_q    <= BOOT_SUPERVISOR;
            redir_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sup_q    <= sup_d;
            redir_q  <= redir_d;
            target_q <= target_d;
        end
    end

    assign supervisor_mode    = sup_q;
    assign flush              = (state_q == ST_FLUSH);
    assign exc_pending        = (state_q == ST_FLUSH);
    assign pc_redirect        = redir_q;
    assign pc_redirect_target = target_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected GPR writes and PC
// redirects, a negedge monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_wb_stage;

    typedef struct {
        bit          isRedirect;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic        injected_nop_init = 1'b0;
    logic        WB_EN_INIT = 1'b0;
    logic        MEM_TO_REG_INIT = 1'b0;
    logic [31:0] read_data_mem = '0;
    logic [31:0] alu_result = '0;
    logic [4:0]  regD_init = '0;
    logic        WB_SYS_EN_INIT = 1'b0;
    logic        is_IRET_INIT = 1'b0;
    logic        TLB_MISS_M_INIT = 1'b0;
    logic        TLB_MISS_D_INIT = 1'b0;
    logic [31:0] PC_INIT = '0;
    logic [31:0] ADDRESS_INIT = '0;
    logic [2:0]  sys_rd_idx = '0;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [31:0] sys_rd_data;
    logic        supervisor_mode;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] pc_redirect_target;
    logic        exc_pending;

    exp_t sbQ[$];
    int   checks = 0;
    int   failures = 0;

    wb_stage dut (
        .clk                (clk),
        .reset              (reset),
        .valid_in           (valid_in),
        .injected_nop_init  (injected_nop_init),
        .WB_EN_INIT         (WB_EN_INIT),
        .MEM_TO_REG_INIT    (MEM_TO_REG_INIT),
        .read_data_mem      (read_data_mem),
        .alu_result         (alu_result),
        .regD_init          (regD_init),
        .WB_SYS_EN_INIT     (WB_SYS_EN_INIT),
        .is_IRET_INIT       (is_IRET_INIT),
        .TLB_MISS_M_INIT    (TLB_MISS_M_INIT),
        .TLB_MISS_D_INIT    (TLB_MISS_D_INIT),
        .PC_INIT            (PC_INIT),
        .ADDRESS_INIT       (ADDRESS_INIT),
        .sys_rd_idx         (sys_rd_idx),
        .reg_we             (reg_we),
        .reg_waddr          (reg_waddr),
        .reg_wdata          (reg_wdata),
        .sys_rd_data        (sys_rd_data),
        .supervisor_mode    (supervisor_mode),
        .flush              (flush),
        .pc_redirect        (pc_redirect),
        .pc_redirect_target (pc_redirect_target),
        .exc_pending        (exc_pending)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkRm(input logic [2:0] idx, input logic [31:0] exp);
        sys_rd_idx = idx;
        #1;
        checkOutput($sformatf("rm%0d", idx), sys_rd_data, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic        v, nop, wbEn, m2r,
        input logic [31:0] rdata, alu,
        input logic [4:0]  regD,
        input logic        sysEn, iret, tlbM, tlbD,
        input logic [31:0] pc, addr
    );
        valid_in          = v;
        injected_nop_init = nop;
        WB_EN_INIT        = wbEn;
        MEM_TO_REG_INIT   = m2r;
        read_data_mem     = rdata;
        alu_result        = alu;
        regD_init         = regD;
        WB_SYS_EN_INIT    = sysEn;
        is_IRET_INIT      = iret;
        TLB_MISS_M_INIT   = tlbM;
        TLB_MISS_D_INIT   = tlbD;
        PC_INIT           = pc;
        ADDRESS_INIT      = addr;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, '0, '0, '0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.isRedirect = 1'b0;
        e.addr = a;
        e.data = d;
        sbQ.push_back(e);
    endtask

    task automatic expectRedirect(input logic [31:0] t);
        exp_t e;
        e.isRedirect = 1'b1;
        e.addr = '0;
        e.data = t;
        sbQ.push_back(e);
    endtask

    // Monitor: every emitted write or redirect must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && reg_we) begin
            checks++;
            if (sbQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h, expected none", reg_waddr, reg_wdata);
            end else begin
                e = sbQ.pop_front();
                if (e.isRedirect || reg_waddr !== e.addr || reg_wdata !== e.data) begin
                    failures++;
                    $display("[TB] FAIL gpr_write: got addr %0d data %h, expected redirect=%0d addr %0d data %h",
                             reg_waddr, reg_wdata, e.isRedirect, e.addr, e.data);
                end
            end
        end
        if (reset && pc_redirect) begin
            checks++;
            if (sbQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_redirect: got target %h, expected none", pc_redirect_target);
            end else begin
                e = sbQ.pop_front();
                if (!e.isRedirect || pc_redirect_target !== e.data) begin
                    failures++;
                    $display("[TB] FAIL redirect: got target %h, expected redirect=%0d target %h",
                             pc_redirect_target, e.isRedirect, e.data);
                end
            end
        end
    end

    initial begin
        idle();
        repeat (2) tick();
        checkOutput("reset_sup", {31'b0, supervisor_mode}, 32'd1);
        checkOutput("reset_flush", {31'b0, flush}, 32'd0);
        checkOutput("reset_pending", {31'b0, exc_pending}, 32'd0);
        checkOutput("reset_redirect", {31'b0, pc_redirect}, 32'd0);
        checkOutput("reset_target", pc_redirect_target, 32'd0);
        checkRm(3'd0, 32'd0);
        checkRm(3'd4, 32'd0);
        reset = 1'b1;
        tick();

        // Load, ALU writeback and a bubble that must not write
        applyStimulus(1, 0, 1, 1, 32'hDEADBEEF, 32'h1111, 5'd5, 0, 0, 0, 0, 32'h100, '0);
        expectWrite(5'd5, 32'hDEADBEEF);
        tick();
        checkOutput("load_noflush", {31'b0, flush}, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'hDEADBEEF, 32'h1234, 5'd7, 0, 0, 0, 0, 32'h104, '0);
        expectWrite(5'd7, 32'h1234);
        tick();
        applyStimulus(1, 1, 1, 0, '0, 32'h9999, 5'd8, 0, 0, 0, 0, 32'h108, '0);
        tick();

        // Supervisor sys writes: scratch, out-of-range index, EPC
        applyStimulus(1, 0, 0, 0, '0, 32'hA5A5, 5'd3, 1, 0, 0, 0, 32'h10C, '0);
        tick();
        applyStimulus(1, 0, 0, 0, '0, 32'h77, 5'd6, 1, 0, 0, 0, 32'h110, '0);
        tick();
        applyStimulus(1, 0, 0, 0, '0, 32'h1000, 5'd0, 1, 0, 0, 0, 32'h114, '0);
        tick();
        idle();
        checkRm(3'd3, 32'hA5A5);
        checkRm(3'd6, 32'd0);
        checkRm(3'd0, 32'h1000);

        // IRET with a colliding rm0 write: redirect to 0x1000, drop to user
        applyStimulus(1, 0, 0, 0, '0, 32'hBAD, 5'd0, 1, 1, 0, 0, 32'h118, '0);
        expectRedirect(32'h1000);
        tick();
        idle();
        checkOutput("iret1_sup", {31'b0, supervisor_mode}, 32'd0);
        checkOutput("iret1_flush_c1", {31'b0, flush}, 32'd1);
        tick();
        checkOutput("iret1_flush_c2", {31'b0, flush}, 32'd1);
        checkOutput("iret1_redirect_drop", {31'b0, pc_redirect}, 32'd0);
        tick();
        checkOutput("iret1_flush_end", {31'b0, flush}, 32'd0);
        checkRm(3'd0, 32'h1000);

        // D-TLB miss in user mode
        applyStimulus(1, 0, 1, 0, '0, 32'h4444, 5'd4, 0, 0, 1, 1, 32'h1040, 32'h8000_0010);
        expectRedirect(32'h2000);
        tick();
        checkOutput("dtlb_sup", {31'b0, supervisor_mode}, 32'd1);
        checkOutput("dtlb_flush_c1", {31'b0, flush}, 32'd1);
        checkOutput("dtlb_pending", {31'b0, exc_pending}, 32'd1);
        checkOutput("dtlb_target", pc_redirect_target, 32'h2000);
        applyStimulus(1, 0, 1, 0, '0, 32'h5555, 5'd6, 0, 0, 1, 0, 32'hFFFF, 32'hEEEE);
        tick();
        idle();
        checkOutput("dtlb_flush_c2", {31'b0, flush}, 32'd1);
        tick();
        checkOutput("dtlb_flush_end", {31'b0, flush}, 32'd0);
        checkRm(3'd0, 32'h1040);
        checkRm(3'd1, 32'h8000_0010);
        checkRm(3'd2, 32'd2);
        checkRm(3'd4, 32'd0);

        // IRET back to 0x1040 in user mode, then writeback resumes
        applyStimulus(1, 0, 0, 0, '0, '0, 5'd0, 0, 1, 0, 0, 32'h2000, '0);
        expectRedirect(32'h1040);
        tick();
        idle();
        checkOutput("iret2_sup", {31'b0, supervisor_mode}, 32'd0);
        repeat (2) tick();
        checkOutput("iret2_flush_end", {31'b0, flush}, 32'd0);
        applyStimulus(1, 0, 1, 0, '0, 32'hCAFE, 5'd9, 0, 0, 0, 0, 32'h1040, '0);
        expectWrite(5'd9, 32'hCAFE);
        tick();

        // User-mode sys write is a privilege fault
        applyStimulus(1, 0, 0, 0, '0, 32'h55, 5'd3, 1, 0, 0, 0, 32'h1100, 32'h44);
        expectRedirect(32'h2000);
        tick();
        idle();
        repeat (2) tick();
        checkRm(3'd3, 32'hA5A5);
        checkRm(3'd2, 32'd3);
        checkRm(3'd0, 32'h1100);
        checkOutput("priv_sup", {31'b0, supervisor_mode}, 32'd1);

        // I-TLB miss in supervisor mode, then reset during the second flush cycle
        applyStimulus(1, 0, 0, 0, '0, '0, 5'd1, 0, 0, 1, 0, 32'h1200, 32'h88);
        expectRedirect(32'h2000);
        tick();
        idle();
        checkRm(3'd2, 32'd1);
        checkRm(3'd4, 32'd1);
        checkRm(3'd0, 32'h1200);
        @(posedge clk);
        #1;
        checkOutput("itlb_flush_c2", {31'b0, flush}, 32'd1);
        sys_rd_idx = 3'd0;
        reset = 1'b0;
        #1;
        checkOutput("async_flush", {31'b0, flush}, 32'd0);
        checkOutput("async_pending", {31'b0, exc_pending}, 32'd0);
        checkOutput("async_sup", {31'b0, supervisor_mode}, 32'd1);
        checkOutput("async_rm0", sys_rd_data, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        checkOutput("scoreboard_empty", sbQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
